regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//   Parametrised multi-read-port register file with a write-to-read bypass and a per-register busy scoreboard.
//   Next-generation integer register file for the RV32I core. Replaces the fixed 2R/1W single-cycle regfile.
//   The scoreboard lets a pipelined front end stall on RAW hazards.
//   x0 is hardwired to zero and is never busy.
// PARAMETERS
//   XLEN    32  data width of each register
//   NREGS   32  number of architectural registers, power of 2, >= 2
//   NRP     2   number of combinational read ports, 1..4
//   BYPASS  1   1: a same-cycle write is forwarded to the read ports; 0: read returns the stored value
//   AW      localparam = $clog2(NREGS), register index width
// PORTS
//   clk        in   1         rising-edge clock
//   rst        in   1         synchronous, active-high reset
//   rs_addr    in   NRP*AW    read indices; port i uses bits [i*AW +: AW]
//   rs_data    out  NRP*XLEN  read data; port i uses bits [i*XLEN +: XLEN]
//   rs_busy    out  NRP       1 = port i's source has a pending (unwritten) producer
//   we         in   1         write enable
//   rd         in   AW        write index
//   wd         in   XLEN      write data
//   iss_valid  in   1         issue strobe: mark iss_rd as busy
//   iss_rd     in   AW        destination of the issued instruction
//   busy_vec   out  NREGS     registered scoreboard state; bit 0 is always 0
//   wr_count   out  32        number of committed writes, saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//   Reset (rst=1 at posedge): all regs <= 0, busy_vec <= 0, wr_count <= 0.
//   - Reset takes priority over a write and an issue in the same cycle.
//   - Reset asserted mid-stream discards that cycle's write and issue.
//   Write: at posedge, if we && rd!=0 && !rst then regs[rd] <= wd and wr_count increments (saturating).
//   - A write with rd==0 is ignored and does not count.
//   Read: combinational, zero latency.
//   - rs_addr==0 -> rs_data = 0 always.
//   - BYPASS=1 && we && rd!=0 && rd==rs_addr[i] -> rs_data[i] = wd (in-flight value), else regs[rs_addr[i]].
//   - BYPASS=0 -> the new value is visible only after the posedge.
//   Scoreboard, at posedge when !rst:
//   - Set: iss_valid && iss_rd!=0 -> busy[iss_rd] <= 1.
//   - Clear: we && rd!=0 -> busy[rd] <= 0.
//   - Same index set and cleared in one cycle -> set wins (the newer producer is outstanding).
//   - Different indices -> both take effect.
//   - Issue to an already-busy reg leaves it busy (WAW is allowed, no error).
//   - We to a non-busy reg is legal: data is written, busy stays 0.
//   rs_busy[i], combinational:
//   - = busy_vec[rs_addr[i]] & ~(BYPASS && we && rd==rs_addr[i]), forced to 0 when rs_addr[i]==0.
//   - A value being bypassed this cycle is therefore never reported as busy.
//   Outputs after reset: rs_data = 0 for all addresses, rs_busy = 0, busy_vec = 0, wr_count = 0.
//   Registers power up X before the first reset; benches must reset first.
// STRUCTURE
//   Shared header rv32_defs.vh holds XLEN_DEF=32, NREGS_DEF=32, REG_X0=5'd0 for the core and its benches.
//   One sub-module, regfile_scoreboard (params NREGS, AW):
//   - inputs: clk, rst, set_en, set_idx, clr_en, clr_idx
//   - output: busy_vec
//   - implements the set-wins rule and the x0 mask.
//   The top level holds the storage array, the read/bypass mux generate loop over NRP, rs_busy and wr_count.
// TESTING
//   Reset, then read x0..x3 on all ports -> every rs_data = 0, rs_busy = 0, busy_vec = 0.
//   Issue x5 (cycle 1); write x5=0xDEADBEEF with rs_addr[0]=5 (cycle 2):
//   - BYPASS=1: rs_data[0] = 0xDEADBEEF and rs_busy[0] = 0 during cycle 2.
//   - After the posedge: busy_vec[5] = 0.
//   Same-cycle iss_rd=7 and we rd=7 (wd=0x77) -> regs[7]=0x77, busy_vec[7]=1 (set wins).
//   - Then a lone write of x7 -> busy_vec[7]=0.
//   Write x0=0xFFFFFFFF and issue x0 -> rs_data for x0 = 0, busy_vec[0] = 0, wr_count unchanged.
//   Write x1=0x11111111 with rst=1 in the same cycle -> x1 reads 0, wr_count = 0.
//   - With BYPASS=0, a same-cycle read of x2 during a write of x2 returns the old value.
//   Four writes to x1..x4 with NRP=4, then read all four ports at once:
//   - rs_data = 0x1111_1111 .. 0x4444_4444, wr_count = 4.

Source files
------------

// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_mp_sb_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int WCNT_W    = 32;
    localparam logic [4:0] REG_X0 = 5'd0;

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
        return (v == '1) ? v : v + WCNT_W'(1);
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, write-back clears, set wins on the same index.
module regfile_scoreboard
    import regfile_mp_sb_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_set_en,
    input  logic [AW-1:0]    i_set_idx,
    input  logic             i_clr_en,
    input  logic [AW-1:0]    i_clr_idx,
    output logic [NREGS-1:0] o_busy_vec
);
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_next;

    // Clear first, then set, so a newer producer issued in the same cycle stays outstanding.
    always_comb begin
        w_next = r_busy;
        if (i_clr_en) w_next[i_clr_idx] = 1'b0;
        if (i_set_en) w_next[i_set_idx] = 1'b1;
        w_next[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_busy <= '0;
        else       r_busy <= w_next;
    end

    assign o_busy_vec = r_busy;
endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with write-to-read bypass, busy scoreboard and write counter.
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRP    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NRP*AW-1:0]   i_rs_addr,
    output logic [NRP*XLEN-1:0] o_rs_data,
    output logic [NRP-1:0]      o_rs_busy,
    input  logic                i_we,
    input  logic [AW-1:0]       i_rd,
    input  logic [XLEN-1:0]     i_wd,
    input  logic                i_iss_valid,
    input  logic [AW-1:0]       i_iss_rd,
    output logic [NREGS-1:0]    o_busy_vec,
    output logic [WCNT_W-1:0]   o_wr_count
);
    logic [XLEN-1:0]   r_regs [NREGS];
    logic [WCNT_W-1:0] r_wr_count;
    logic [NREGS-1:0]  w_busy_vec;
    logic              w_wr_req;
    logic              w_iss_req;

    // A write to x0 is architecturally a no-op; it neither stores, counts nor bypasses.
    assign w_wr_req  = i_we && (i_rd != AW'(REG_X0));
    assign w_iss_req = i_iss_valid && (i_iss_rd != AW'(REG_X0));

    // Storage and commit counter; reset drops the same-cycle write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
            r_wr_count <= '0;
        end else if (w_wr_req) begin
            r_regs[i_rd] <= i_wd;
            r_wr_count   <= sat_inc(r_wr_count);
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_set_en   (w_iss_req),
        .i_set_idx  (i_iss_rd),
        .i_clr_en   (w_wr_req),
        .i_clr_idx  (i_rd),
        .o_busy_vec (w_busy_vec)
    );

    // Read ports: x0 reads zero, an in-flight write is forwarded when bypass is enabled,
    // and a forwarded value is never reported busy.
    for (genvar g = 0; g < NRP; g++) begin : g_rp
        logic [AW-1:0] w_addr;
        logic          w_hit;
        logic          w_x0;
        assign w_addr = i_rs_addr[g*AW +: AW];
        assign w_x0   = (w_addr == AW'(REG_X0));
        assign w_hit  = (BYPASS != 0) && w_wr_req && (i_rd == w_addr);
        assign o_rs_data[g*XLEN +: XLEN] = w_x0 ? '0 : (w_hit ? i_wd : r_regs[w_addr]);
        assign o_rs_busy[g] = !w_x0 && w_busy_vec[w_addr] && !w_hit;
    end

    assign o_busy_vec = w_busy_vec;
    assign o_wr_count = r_wr_count;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench: a bypassing and a non-bypassing 4-port instance share stimulus and are checked
// against directed table rows and a behavioural model.
module tb_regfile_mp_sb;
    logic         clk;
    logic         rst;
    logic [19:0]  rs_addr;
    logic         we;
    logic [4:0]   rd;
    logic [31:0]  wd;
    logic         iss_valid;
    logic [4:0]   iss_rd;

    logic [127:0] d_b,  d_n;
    logic [3:0]   b_b,  b_n;
    logic [31:0]  bv_b, bv_n;
    logic [31:0]  cnt_b, cnt_n;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural state
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic [31:0] m_cnt;

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRP(4), .BYPASS(1)) u_byp (
        .i_clk(clk), .i_rst(rst), .i_rs_addr(rs_addr), .o_rs_data(d_b), .o_rs_busy(b_b),
        .i_we(we), .i_rd(rd), .i_wd(wd), .i_iss_valid(iss_valid), .i_iss_rd(iss_rd),
        .o_busy_vec(bv_b), .o_wr_count(cnt_b));

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRP(4), .BYPASS(0)) u_nob (
        .i_clk(clk), .i_rst(rst), .i_rs_addr(rs_addr), .o_rs_data(d_n), .o_rs_busy(b_n),
        .i_we(we), .i_rd(rd), .i_wd(wd), .i_iss_valid(iss_valid), .i_iss_rd(iss_rd),
        .o_busy_vec(bv_n), .o_wr_count(cnt_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst, we;
        logic [4:0]   rd;
        logic [31:0]  wd;
        logic         iv;
        logic [4:0]   ird;
        logic [19:0]  a;     // {a3,a2,a1,a0}
        logic [127:0] xd;    // bypass instance data {d3,d2,d1,d0}
        logic [31:0]  xdn0;  // non-bypass instance, port 0
        logic [3:0]   xb;    // bypass instance rs_busy
        logic [31:0]  xbv;   // busy_vec after the edge
        logic [31:0]  xcnt;  // wr_count after the edge
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, input logic w, input logic [4:0] d, input logic [31:0] v,
                       input logic iv, input logic [4:0] ir, input logic [19:0] a,
                       input logic [127:0] xd, input logic [31:0] xdn0, input logic [3:0] xb,
                       input logic [31:0] xbv, input logic [31:0] xcnt);
        vec_t t;
        t.rst = r; t.we = w; t.rd = d; t.wd = v; t.iv = iv; t.ird = ir; t.a = a;
        t.xd = xd; t.xdn0 = xdn0; t.xb = xb; t.xbv = xbv; t.xcnt = xcnt;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_data(input bit byp, input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (byp && we && rd != 0 && rd == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic m_rbusy(input bit byp, input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (byp && we && rd == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic drive(input logic r, input logic w, input logic [4:0] d, input logic [31:0] v,
                         input logic iv, input logic [4:0] ir, input logic [19:0] a);
        rst = r; we = w; rd = d; wd = v; iss_valid = iv; iss_rd = ir; rs_addr = a;
    endtask

    task automatic check_comb();
        for (int p = 0; p < 4; p++) begin
            logic [4:0] a;
            a = rs_addr[p*5 +: 5];
            chk($sformatf("byp_data%0d x%0d", p, a), d_b[p*32 +: 32], m_data(1'b1, a));
            chk($sformatf("nob_data%0d x%0d", p, a), d_n[p*32 +: 32], m_data(1'b0, a));
            chk($sformatf("byp_busy%0d x%0d", p, a), {31'd0, b_b[p]}, {31'd0, m_rbusy(1'b1, a)});
            chk($sformatf("nob_busy%0d x%0d", p, a), {31'd0, b_n[p]}, {31'd0, m_rbusy(1'b0, a)});
        end
    endtask

    // Advance one clock, update the model with the rules for the applied inputs,
    // then check registered outputs on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
            m_busy = 32'h0;
            m_cnt  = 32'h0;
        end else begin
            if (we && rd != 0) begin
                m_regs[rd] = wd;
                m_busy[rd] = 1'b0;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
        @(negedge clk);
        chk("byp_busy_vec", bv_b, m_busy);
        chk("nob_busy_vec", bv_n, m_busy);
        chk("byp_wr_count", cnt_b, m_cnt);
        chk("nob_wr_count", cnt_n, m_cnt);
    endtask

    initial begin
        m_busy = 32'h0;
        m_cnt  = 32'h0;
        for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;

        //   rst we rd     wd             iv ird    a (a3..a0)                  xd (d3..d0)                                   xdn0          xb       xbv           xcnt
        add(0, 0, 5'd0, 32'h0,         0, 5'd0, {5'd3,5'd2,5'd1,5'd0},      128'h0,                                      32'h0,        4'b0000, 32'h0,        32'd0);
        add(0, 0, 5'd0, 32'h0,         1, 5'd5, {15'd0,5'd5},               128'h0,                                      32'h0,        4'b0000, 32'h0000_0020,32'd0);
        add(0, 1, 5'd5, 32'hDEADBEEF,  0, 5'd0, {15'd0,5'd5},               {96'h0,32'hDEADBEEF},                        32'h0,        4'b0000, 32'h0,        32'd1);
        add(0, 1, 5'd7, 32'h77,        1, 5'd7, {15'd0,5'd7},               {96'h0,32'h77},                              32'h0,        4'b0000, 32'h0000_0080,32'd2);
        add(0, 0, 5'd0, 32'h0,         0, 5'd0, {15'd0,5'd7},               {96'h0,32'h77},                              32'h77,       4'b0001, 32'h0000_0080,32'd2);
        add(0, 1, 5'd7, 32'h78,        1, 5'd9, {15'd0,5'd7},               {96'h0,32'h78},                              32'h77,       4'b0000, 32'h0000_0200,32'd3);
        add(0, 0, 5'd0, 32'h0,         1, 5'd9, {15'd0,5'd9},               128'h0,                                      32'h0,        4'b0001, 32'h0000_0200,32'd3);
        add(0, 1, 5'd9, 32'h99,        0, 5'd0, {15'd0,5'd9},               {96'h0,32'h99},                              32'h0,        4'b0000, 32'h0,        32'd4);
        add(0, 1, 5'd0, 32'hFFFFFFFF,  1, 5'd0, {15'd0,5'd0},               128'h0,                                      32'h0,        4'b0000, 32'h0,        32'd4);
        add(1, 1, 5'd1, 32'h11111111,  1, 5'd3, {15'd0,5'd1},               {96'h0,32'h11111111},                        32'h0,        4'b0000, 32'h0,        32'd0);
        add(0, 0, 5'd0, 32'h0,         0, 5'd0, {5'd5,5'd7,5'd9,5'd1},      128'h0,                                      32'h0,        4'b0000, 32'h0,        32'd0);
        add(0, 1, 5'd2, 32'h22,        0, 5'd0, {15'd0,5'd2},               {96'h0,32'h22},                              32'h0,        4'b0000, 32'h0,        32'd1);
        add(0, 1, 5'd2, 32'h2222,      0, 5'd0, {15'd0,5'd2},               {96'h0,32'h2222},                            32'h22,       4'b0000, 32'h0,        32'd2);
        add(1, 0, 5'd0, 32'h0,         0, 5'd0, 20'h0,                      128'h0,                                      32'h0,        4'b0000, 32'h0,        32'd0);
        add(0, 1, 5'd1, 32'h11111111,  0, 5'd0, 20'h0,                      128'h0,                                      32'h0,        4'b0000, 32'h0,        32'd1);
        add(0, 1, 5'd2, 32'h22222222,  0, 5'd0, 20'h0,                      128'h0,                                      32'h0,        4'b0000, 32'h0,        32'd2);
        add(0, 1, 5'd3, 32'h33333333,  0, 5'd0, 20'h0,                      128'h0,                                      32'h0,        4'b0000, 32'h0,        32'd3);
        add(0, 1, 5'd4, 32'h44444444,  0, 5'd0, 20'h0,                      128'h0,                                      32'h0,        4'b0000, 32'h0,        32'd4);
        add(0, 0, 5'd0, 32'h0,         0, 5'd0, {5'd4,5'd3,5'd2,5'd1},
            {32'h44444444,32'h33333333,32'h22222222,32'h11111111},                                                          32'h11111111, 4'b0000, 32'h0,        32'd4);

        // Power-up reset, two cycles
        drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 20'h0);
        tick();
        tick();

        // Directed rows
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].we, tbl[i].rd, tbl[i].wd, tbl[i].iv, tbl[i].ird, tbl[i].a);
            #1;
            check_comb();
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("row%0d byp_data%0d", i, p), d_b[p*32 +: 32], tbl[i].xd[p*32 +: 32]);
                chk($sformatf("row%0d byp_busy%0d", i, p), {31'd0, b_b[p]}, {31'd0, tbl[i].xb[p]});
            end
            chk($sformatf("row%0d nob_data0", i), d_n[31:0], tbl[i].xdn0);
            tick();
            chk($sformatf("row%0d busy_vec", i), bv_b, tbl[i].xbv);
            chk($sformatf("row%0d wr_count", i), cnt_b, tbl[i].xcnt);
        end

        // Random traffic on a narrow index range to provoke hits and hazards
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))});
            #1;
            check_comb();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
